// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Memory-stage access engine. Takes the effective address and store data from
// the EX/MEM register, runs each load or store as a single req/ack transaction
// on the data bus, and returns the lane-selected, sign/zero-extended load
// result for forwarding and writeback. The pipeline is stalled while an access
// is outstanding.
//
// Parameters
//   TIMEOUT  cycles bus_req may wait for bus_ack before the access faults
//   CNT_W    width of the wait counter (must hold TIMEOUT)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   ex_valid         EX/MEM holds a valid instruction
//   ex_opcode        opcode; only loads and stores start an access
//   ex_funct3        access size / signedness
//   ex_addr          effective address
//   ex_store_data    store data
//   ex_rd            load destination register
//   stall            freeze IF/ID/EX and the EX/MEM register
//   bus_req          transaction request, held until bus_ack or timeout
//   bus_we           1 = write
//   bus_addr         word-aligned address
//   bus_wdata        lane-replicated store data
//   bus_wstrb        byte enables (0000 for loads)
//   bus_ack          one-cycle completion pulse
//   bus_rdata        read word, valid with bus_ack
//   mem_valid        one-cycle pulse: access completed
//   Data_mem_Mem     extended load result, 0 after a store
//   mem_rd           rd of the completed load, 0 after a store
//   mem_fault        one-cycle pulse: misaligned, illegal funct3 or timeout
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [6:0]  ex_opcode,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        mem_valid,
   output logic [31:0] Data_mem_Mem,
   output logic [4:0]  mem_rd,
   output logic        mem_fault
);

   localparam logic [6:0]       OP_LOAD  = 7'b0000011;
   localparam logic [6:0]       OP_STORE = 7'b0100011;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;

   // transaction fields captured at acceptance
   logic             we_p1;
   logic [2:0]       f3_p1;
   logic [1:0]       off_p1;
   logic [4:0]       rd_p1;

   logic is_load, is_store, acc_req, acc_legal;
   logic accept, reject, stall_c, timeout_hit;

   // ---------------------------------------------------------------------------
   // Access rules
   // ---------------------------------------------------------------------------
   function automatic logic is_legal(input logic store, input logic [2:0] f3,
                                     input logic [1:0] off);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;                       // LB / SB
         3'b001:  ok = ~off[0];                    // LH / SH
         3'b010:  ok = (off == 2'b00);             // LW / SW
         3'b100:  ok = ~store;                     // LBU
         3'b101:  ok = ~store & ~off[0];           // LHU
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << off;
         2'b01:   s = 4'b0011 << {off[1], 1'b0};
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [2:0] f3,
                                            input logic [1:0] off);
      logic [31:0] lane;
      logic [31:0] r;
      lane = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  r = {{24{lane[7]}}, lane[7:0]};
         3'b001:  r = {{16{lane[15]}}, lane[15:0]};
         3'b100:  r = {24'b0, lane[7:0]};
         3'b101:  r = {16'b0, lane[15:0]};
         default: r = rdata;
      endcase
      return r;
   endfunction

   assign is_load     = (ex_opcode == OP_LOAD);
   assign is_store    = (ex_opcode == OP_STORE);
   // A faulting instruction is still sitting in EX/MEM the cycle after its
   // fault (it was stalled while we decided); mem_fault marks that cycle so the
   // instruction is dropped and the pipeline moves on instead of faulting again.
   assign acc_req     = ex_valid & (is_load | is_store) & ~mem_fault;
   assign acc_legal   = is_legal(is_store, ex_funct3, ex_addr[1:0]);
   assign timeout_hit = (cnt == CNT_LAST);

   // ---------------------------------------------------------------------------
   // Next state / stall
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      case (state)
         IDLE: begin
            if (acc_req) begin
               stall_c = 1'b1;
               if (acc_legal) begin
                  accept    = 1'b1;
                  state_nxt = BUSY;
               end else begin
                  reject    = 1'b1;
               end
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            // ack wins over a coincident timeout
            if (bus_ack)          state_nxt = RESP;
            else if (timeout_hit) state_nxt = IDLE;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // reset forces the pipeline free even if EX still presents an access
   assign stall = rst_n & stall_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------------------------------------------------------------------
   // Bus request / response registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_wstrb    <= '0;
         mem_valid    <= 1'b0;
         Data_mem_Mem <= '0;
         mem_rd       <= '0;
         mem_fault    <= 1'b0;
      end else begin
         mem_valid <= 1'b0;
         mem_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt       <= '0;
                  bus_req   <= 1'b1;
                  bus_we    <= is_store;
                  bus_addr  <= {ex_addr[31:2], 2'b00};
                  bus_wdata <= store_lanes(ex_funct3, ex_store_data);
                  bus_wstrb <= is_store ? store_strb(ex_funct3, ex_addr[1:0]) : 4'b0000;
               end else if (reject) begin
                  mem_fault <= 1'b1;
               end
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (bus_ack) begin
                  bus_req   <= 1'b0;
                  mem_valid <= 1'b1;
                  if (we_p1) begin
                     Data_mem_Mem <= '0;
                     mem_rd       <= '0;
                  end else begin
                     Data_mem_Mem <= load_ext(bus_rdata, f3_p1, off_p1);
                     mem_rd       <= rd_p1;
                  end
               end else if (timeout_hit) begin
                  bus_req   <= 1'b0;
                  mem_fault <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Transaction capture (only meaningful while BUSY)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p1  <= is_store;
         f3_p1  <= ex_funct3;
         off_p1 <= ex_addr[1:0];
         rd_p1  <= ex_rd;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   localparam int         TMO      = 4;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic [6:0]  ex_opcode = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_addr = '0;
   logic [31:0] ex_store_data = '0;
   logic [4:0]  ex_rd = '0;
   logic        stall, bus_req, bus_we, mem_valid, mem_fault;
   logic [31:0] bus_addr, bus_wdata, Data_mem_Mem;
   logic [3:0]  bus_wstrb;
   logic [4:0]  mem_rd;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   logic        resp_ack = 1'b0, stray_ack = 1'b0;
   logic [31:0] resp_rdata = '0, stray_rdata = '0;
   assign bus_ack   = resp_ack | stray_ack;
   assign bus_rdata = stray_ack ? stray_rdata : resp_rdata;

   mem_access_unit #(.TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .mem_valid(mem_valid),
      .Data_mem_Mem(Data_mem_Mem), .mem_rd(mem_rd), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          fault;
      logic [31:0] data;
      logic [4:0]  rd;
      int          when;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      int          dly;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];
   bit    aborting = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit legal_of(input bit st, input logic [2:0] f3, input logic [31:0] addr);
      bit f3_ok;
      f3_ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return f3_ok && ((addr % 32'(size_of(f3))) == 0);
   endfunction

   function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [2:0] f3,
                                              input logic [31:0] addr);
      longint full, v;
      int     sz, off;
      sz   = size_of(f3);
      off  = int'(addr % 4);
      full = longint'(1) << (8 * sz);
      v    = (longint'(rdata) >> (8 * off)) % full;
      if (!f3[2] && v >= full / 2) v = v - full;
      return v[31:0];
   endfunction

   function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] s;
      int off, sz;
      off = int'(addr % 4);
      sz  = size_of(f3);
      s   = '0;
      for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      int sz;
      sz = size_of(f3);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
      return w;
   endfunction

   // ---------------- stimulus: one EX/MEM instruction, held while stalled ----------------
   // Called at posedge+1; returns at posedge+1 after the instruction was consumed.
   task automatic do_op(input bit mem, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] d, input logic [4:0] rd, input logic [31:0] rdata,
                        input int dly);
      bit    legal, tmo;
      int    exp_stall, lat, n;
      resp_t r;
      bus_t  b;
      legal = mem && legal_of(st, f3, addr);
      tmo   = legal && (dly < 0 || dly >= TMO);
      if (!mem)       exp_stall = 0;
      else if (!legal) exp_stall = 1;
      else if (tmo)    exp_stall = 1 + TMO;
      else             exp_stall = dly + 2;
      lat = !legal ? 1 : (tmo ? TMO + 1 : dly + 2);
      if (legal) begin
         b.we    = st;
         b.addr  = addr & 32'hFFFF_FFFC;
         b.wdata = wdata_model(f3, d);
         b.wstrb = st ? strb_model(f3, addr) : 4'b0000;
         b.rdata = rdata;
         b.dly   = dly;
         bus_q.push_back(b);
      end
      if (mem) begin
         r.fault = !legal || tmo;
         r.data  = st ? 32'h0 : load_model(rdata, f3, addr);
         r.rd    = st ? 5'd0 : rd;
         r.when  = cyc + lat;
         resp_q.push_back(r);
      end
      ex_valid      = 1'b1;
      ex_opcode     = mem ? (st ? OP_STORE : OP_LOAD) : OP_ALU;
      ex_funct3     = f3;
      ex_addr       = addr;
      ex_store_data = d;
      ex_rd         = rd;
      n = 0;
      @(negedge clk);
      while (stall && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("stall_cycles", 32'(n), 32'(exp_stall));
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
   endtask

   // ---------------- bus responder ----------------
   bus_t        rb;
   int          hi;
   bit          stable;
   logic [31:0] w0;

   initial begin : responder
      forever begin
         @(negedge clk);
         if (bus_req === 1'b1) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bus_req: bus_req=1 addr=0x%08h with no access issued", bus_addr);
            end else begin
               rb = bus_q.pop_front();
               check("bus_we", 32'(bus_we), 32'(rb.we));
               check("bus_addr", bus_addr, rb.addr);
               check("bus_wstrb", 32'(bus_wstrb), 32'(rb.wstrb));
               if (rb.we) check("bus_wdata", bus_wdata, rb.wdata);
               w0     = bus_wdata;
               hi     = 0;
               stable = 1'b1;
               while (bus_req === 1'b1 && hi < 300) begin
                  if ({bus_we, bus_addr, bus_wstrb, bus_wdata} !== {rb.we, rb.addr, rb.wstrb, w0})
                     stable = 1'b0;
                  if (hi == rb.dly) begin
                     resp_ack   = 1'b1;
                     resp_rdata = rb.rdata;
                  end
                  @(negedge clk);
                  resp_ack   = 1'b0;
                  resp_rdata = $urandom;
                  hi++;
               end
               check("bus_stable", 32'(stable), 32'd1);
               if (!aborting)
                  check("bus_req_cycles", 32'(hi),
                        32'((rb.dly >= 0 && rb.dly < TMO) ? rb.dly + 1 : TMO));
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   resp_t mon_r;

   always @(negedge clk) begin
      if (mem_valid === 1'b1 || mem_fault === 1'b1) begin
         if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: mem_valid=%0b mem_fault=%0b with nothing outstanding",
                     mem_valid, mem_fault);
         end else begin
            mon_r = resp_q.pop_front();
            check("resp_fault", 32'(mem_fault), 32'(mon_r.fault));
            check("resp_valid", 32'(mem_valid), 32'(!mon_r.fault));
            check("resp_cycle", 32'(cyc), 32'(mon_r.when));
            if (!mon_r.fault) begin
               check("Data_mem_Mem", Data_mem_Mem, mon_r.data);
               check("mem_rd", 32'(mem_rd), 32'(mon_r.rd));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      bit          r_mem, r_st;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      int          r_dly, tmp;
      bit          bad;
      logic [31:0] held;
      bus_t        ab;

      // reset with a legal load presented: everything quiet, no stall
      ex_valid  = 1'b1;
      ex_opcode = OP_LOAD;
      ex_funct3 = 3'b010;
      ex_addr   = 32'h100;
      repeat (3) @(negedge clk);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_bus_we", 32'(bus_we), 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", bus_wdata, 32'd0);
      check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_data", Data_mem_Mem, 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_mem_fault", 32'(mem_fault), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      ex_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // directed cases
      do_op(1, 1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd3, 32'h0, 2);        // SW
      do_op(1, 0, 3'b000, 32'h203, 32'h0, 5'd5, 32'h80FF1234, 0);          // LB
      do_op(1, 0, 3'b100, 32'h203, 32'h0, 5'd6, 32'h80FF1234, 0);          // LBU
      do_op(1, 1, 3'b001, 32'h12, 32'h0000ABCD, 5'd0, 32'h0, 1);           // SH
      do_op(1, 0, 3'b001, 32'h12, 32'h0, 5'd9, 32'h7FFE0000, 0);           // LH
      do_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd1, 32'h0, 0);                 // LW misaligned
      do_op(1, 0, 3'b011, 32'h100, 32'h0, 5'd1, 32'h0, 0);                 // bad load funct3
      do_op(1, 1, 3'b100, 32'h100, 32'h1, 5'd1, 32'h0, 0);                 // bad store funct3
      do_op(0, 0, 3'b010, 32'h100, 32'h0, 5'd2, 32'h0, 0);                 // non-memory op
      do_op(1, 0, 3'b010, 32'h40, 32'h0, 5'd4, 32'h12345678, -1);          // timeout
      do_op(1, 0, 3'b010, 32'h44, 32'h0, 5'd7, 32'hCAFEF00D, TMO - 1);     // ack on timeout cycle
      do_op(1, 0, 3'b101, 32'h2A, 32'h0, 5'd8, 32'hFEDC0000, 1);           // LHU upper half

      // randomized accesses
      for (int i = 0; i < 80; i++) begin
         r_mem = ($urandom_range(0, 9) != 0);
         r_st  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) != 0) begin
            if (r_st) begin
               r_f3 = 3'($urandom_range(0, 2));
            end else begin
               tmp  = int'($urandom_range(0, 4));
               r_f3 = 3'(tmp < 3 ? tmp : tmp + 1);
            end
         end else begin
            r_f3 = 3'($urandom_range(0, 7));
         end
         r_addr = $urandom;
         if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'(size_of(r_f3)) - 32'd1);
         r_dly = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TMO - 1)) : -1;
         do_op(r_mem, r_st, r_f3, r_addr, $urandom, 5'($urandom_range(0, 31)), $urandom, r_dly);
      end

      // stray ack while idle: no response, no bus activity, result unchanged
      held        = Data_mem_Mem;
      stray_rdata = 32'h5555AAAA;
      stray_ack   = 1'b1;
      @(posedge clk);
      #1;
      stray_ack = 1'b0;
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mem_valid !== 1'b0 || mem_fault !== 1'b0 || bus_req !== 1'b0) bad = 1'b1;
      end
      check("stray_ack_quiet", 32'(bad), 32'd0);
      check("stray_ack_data", Data_mem_Mem, held);
      @(posedge clk);
      #1;

      // reset while BUSY: request and stall drop at once, nothing reported
      ab.we = 1'b0; ab.addr = 32'h300; ab.wdata = '0; ab.wstrb = 4'b0000;
      ab.rdata = 32'h0; ab.dly = 50;
      bus_q.push_back(ab);
      ex_valid  = 1'b1;
      ex_opcode = OP_LOAD;
      ex_funct3 = 3'b010;
      ex_addr   = 32'h300;
      ex_rd     = 5'd11;
      repeat (3) @(negedge clk);
      check("busy_before_rst", 32'(bus_req), 32'd1);
      aborting = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_busy_bus_req", 32'(bus_req), 32'd0);
      check("rst_busy_stall", 32'(stall), 32'd0);
      ex_valid = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      aborting = 1'b0;
      bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (mem_valid !== 1'b0 || mem_fault !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0)
            bad = 1'b1;
      end
      check("after_rst_quiet", 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      do_op(1, 0, 3'b000, 32'h301, 32'h0, 5'd12, 32'h00007F00, 0);        // LB after reset

      repeat (10) @(negedge clk);
      check("resp_q_empty", 32'(resp_q.size()), 32'd0);
      check("bus_q_empty", 32'(bus_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage consumer of the execution stage's `ALU_result` (effective address) and `Rdata2_out` (forwarded store data).
- Runs each load/store as a req/ack transaction on the data bus.
- Handles byte-lane alignment, write strobes and load sign/zero extension.
- Stalls the pipeline while a transaction is outstanding, then presents the load result as `Data_mem_Mem` for MEM→EX forwarding and writeback.

Parameters:
- TIMEOUT, 255: maximum cycles `bus_req` may wait for `bus_ack` before the access is aborted with a fault.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX/MEM register holds a valid instruction this cycle
- ex_opcode  input  7  opcode; only `I_TYPE_LOAD` and `S_TYPE` start an access
- ex_funct3  input  3  access size/sign
- ex_addr  input  32  effective address (`ALU_result`)
- ex_store_data  input  32  store data (`Rdata2_out`)
- ex_rd  input  5  load destination register
- stall  output  1  freeze IF/ID/EX and the EX/MEM register
- bus_req  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address, {ex_addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_wstrb  output  4  byte enables
- bus_ack  input  1  one-cycle completion pulse
- bus_rdata  input  32  read word, valid with bus_ack
- mem_valid  output  1  one-cycle pulse: access completed
- Data_mem_Mem  output  32  extended load result; 0 for stores
- mem_rd  output  5  rd of the completed load; 0 for stores
- mem_fault  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter=0.
  - All registered outputs are 0: bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, mem_valid, Data_mem_Mem, mem_rd, mem_fault.
  - bus_req drops immediately, even mid-transaction; no result or fault is reported for the aborted access.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Access request = ex_valid & (opcode is load or store).
  - stall = access request (combinational), so EX holds while the access is taken.
  - Legal request:
    - latch we, funct3, addr[1:0], rd, bus_addr, bus_wdata, bus_wstrb;
    - set bus_req=1 and counter=0;
    - → BUSY.
  - Illegal request:
    - mem_fault=1 for one cycle, no bus activity, stay IDLE.
    - stall is asserted for that single cycle only.
  - Non-memory instructions: no action, stall=0.
- Legality rules:
  - funct3 ∈ {000,001,010,100,101} for loads and {000,001,010} for stores.
  - Halfword needs addr[0]=0; word needs addr[1:0]=00.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{d[15:0]}}.
  - SW: wstrb=1111, wdata=d.
  - Loads drive wstrb=0000.
- BUSY:
  - stall=1.
  - bus_req, bus_we, bus_addr, bus_wdata and bus_wstrb hold stable until ack.
  - Counter increments each cycle.
  - bus_ack=1:
    - drop bus_req;
    - for a load, select the lane by latched addr[1:0] and sign-/zero-extend per funct3 (LB/LH sign, LBU/LHU zero, LW full) into Data_mem_Mem;
    - → RESP.
  - Timeout: counter reaches TIMEOUT with no ack → drop bus_req, pulse mem_fault, → IDLE. An ack in the same cycle as the timeout takes priority (completes normally).
- RESP:
  - mem_valid=1 and mem_rd=latched rd for one cycle.
  - stall=0, so the pipeline advances this cycle.
  - → IDLE.
  - Data_mem_Mem and mem_rd hold their values until the next completion; Data_mem_Mem is cleared to 0 on store completion.
- Latency: request accepted at cycle N; bus_req visible from N+1. If bus_ack arrives at cycle M (M≥N+1), mem_valid is at M+1. Zero-wait load: result at N+2.
- Ack handling:
  - bus_ack in IDLE or RESP is ignored.
  - bus_rdata is sampled only on an ack in BUSY.
- The next access is not accepted in the RESP cycle; earliest acceptance is the following IDLE cycle.

Test Plan:
- SW addr=0x104 data=0xDEADBEEF, ack 2 cycles after req → bus_addr=0x104, wstrb=1111, wdata=0xDEADBEEF, stall high 4 cycles, mem_valid pulse, Data_mem_Mem=0.
- LB addr=0x203, bus_rdata=0x80FF1234, zero-wait ack → wstrb=0000, Data_mem_Mem=0xFFFFFF80 two cycles after acceptance, mem_rd=latched rd; LBU same → 0x00000080.
- SH addr=0x12 data=0x0000ABCD → wstrb=1100, wdata=0xABCDABCD; LH addr=0x12 rdata=0x7FFE0000 → 0x00007FFE.
- LW addr=0x102 → mem_fault pulse, bus_req never asserted, stall high one cycle only; funct3=011 load → same fault.
- No ack with TIMEOUT=4 → bus_req held 4 cycles then drops, mem_fault pulse, no mem_valid; ack coincident with the timeout cycle → normal completion, no fault.
- rst_n low mid-BUSY → bus_req and stall 0 immediately, state IDLE, no mem_valid or mem_fault after release; a stray ack in IDLE → no output.
